// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
// Provides the coin codes, the coin value decode and the controller state type.
package vend_pkg;

  localparam int unsigned COIN_W  = 2;
  localparam int unsigned VALUE_W = 6;

  localparam logic [COIN_W-1:0] COIN_10  = 2'b00;
  localparam logic [COIN_W-1:0] COIN_20  = 2'b01;
  localparam logic [COIN_W-1:0] COIN_50  = 2'b10;
  localparam logic [COIN_W-1:0] COIN_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_PAYOUT
  } state_t;

  // Coin code to value in units; the invalid code is worth nothing.
  function automatic logic [VALUE_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    case (code)
      COIN_10: return VALUE_W'(10);
      COIN_20: return VALUE_W'(20);
      COIN_50: return VALUE_W'(50);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Change selection: picks the largest coin (50/20/10) not exceeding the credit.
// Ports:
//   credit       in   remaining change in units
//   change_coin  out  selected denomination code (COIN_10 when credit < 10)
//   value        out  value of the selected coin, 0 when credit < 10
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [COIN_W-1:0]   change_coin,
  output logic [CREDIT_W-1:0] value
);

  // Largest-first denomination choice.
  always_comb begin
    change_coin = COIN_10;
    if (credit >= CREDIT_W'(50)) begin
      change_coin = COIN_50;
    end else if (credit >= CREDIT_W'(20)) begin
      change_coin = COIN_20;
    end
    value = (credit >= CREDIT_W'(10)) ? CREDIT_W'(coin_value(change_coin)) : '0;
  end

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: collects credit, requests a vend, pays change.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   coin_valid, coin    coin presented this cycle and its code
//   cancel              refund request (honoured while collecting)
//   vend_ack            dispenser accepted the vend
//   change_ready        hopper accepts a change coin this cycle
//   vend                vend request, held until acknowledged
//   change_valid        change coin offered
//   change_coin         offered denomination code
//   coin_reject         registered pulse, previous cycle's coin was returned
//   credit              current credit / remaining change
//   busy                vending or paying out
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 40,
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                change_ready,
  output logic                vend,
  output logic                change_valid,
  output logic [COIN_W-1:0]   change_coin,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Price must be a positive multiple of 10 and leave room for a 50 on top of PRICE-10.
  if ((PRICE % 10) != 0 || PRICE < 10 ||
      (64'(PRICE) + 64'd40) >= (64'd1 << CREDIT_W)) begin : g_bad_params
    $error("vend_ctrl: PRICE must be a multiple of 10 with PRICE+40 < 2**CREDIT_W");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic                coin_ok;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [COIN_W-1:0]   sel_coin;
  logic [CREDIT_W-1:0] sel_value;
  logic [CREDIT_W-1:0] remain;

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_sel (
    .credit      (credit_q),
    .change_coin (sel_coin),
    .value       (sel_value)
  );

  // Credit after accepting the presented coin (invalid code adds nothing).
  assign coin_ok  = coin_valid && (coin != COIN_BAD);
  assign coin_val = CREDIT_W'(coin_value(coin));
  assign sum      = credit_q + (coin_ok ? coin_val : '0);
  assign remain   = credit_q - sel_value;

  // State, credit and reject-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Next-state and credit update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        reject_d = coin_valid && (coin == COIN_BAD);
        if (state_q == ST_COLLECT && cancel) begin
          // Refund beats reaching the price in the same cycle.
          state_d  = ST_PAYOUT;
          credit_d = sum;
        end else if (coin_ok) begin
          if (sum >= PRICE_C) begin
            state_d  = ST_VEND;
            credit_d = sum - PRICE_C;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum;
          end
        end
      end
      ST_VEND: begin
        reject_d = coin_valid;
        if (vend_ack) begin
          state_d = (credit_q != '0) ? ST_PAYOUT : ST_IDLE;
        end
      end
      ST_PAYOUT: begin
        reject_d = coin_valid;
        if (change_ready) begin
          credit_d = remain;
          if (remain == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Outputs decoded from registers only.
  assign vend         = (state_q == ST_VEND);
  assign change_valid = (state_q == ST_PAYOUT);
  assign change_coin  = change_valid ? sel_coin : COIN_10;
  assign busy         = (state_q == ST_VEND) || (state_q == ST_PAYOUT);
  assign credit       = credit_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the vending rules.
module tb_vend_ctrl;

  localparam int PRICE = 40;
  localparam int CW    = 8;

  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_VEND    = 2;
  localparam int P_PAY     = 3;

  logic          clk;
  logic          reset_n;
  logic          coin_valid;
  logic [1:0]    coin;
  logic          cancel;
  logic          vend_ack;
  logic          change_ready;
  logic          vend;
  logic          change_valid;
  logic [1:0]    change_coin;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic          busy;

  int n_tests;
  int n_fail;
  int m_phase;
  int m_credit;
  int m_reject;
  int paid_total;

  vend_ctrl #(.PRICE(PRICE), .CREDIT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_valid   (coin_valid),
    .coin         (coin),
    .cancel       (cancel),
    .vend_ack     (vend_ack),
    .change_ready (change_ready),
    .vend         (vend),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int coin_units(input int code);
    case (code)
      0: return 10;
      1: return 20;
      2: return 50;
      default: return 0;
    endcase
  endfunction

  function automatic int largest_change(input int amount);
    int denoms[3];
    denoms = '{50, 20, 10};
    for (int i = 0; i < 3; i++) begin
      if (denoms[i] <= amount) return denoms[i];
    end
    return 0;
  endfunction

  function automatic int units_to_code(input int units);
    if (units == 50) return 2;
    if (units == 20) return 1;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int exp_coin;
    exp_coin = (m_phase == P_PAY) ? units_to_code(largest_change(m_credit)) : 0;
    check("vend",         int'(vend),         int'(m_phase == P_VEND));
    check("change_valid", int'(change_valid), int'(m_phase == P_PAY));
    check("change_coin",  int'(change_coin),  exp_coin);
    check("coin_reject",  int'(coin_reject),  m_reject);
    check("credit",       int'(credit),       m_credit);
    check("busy",         int'(busy),         int'(m_phase == P_VEND || m_phase == P_PAY));
  endtask

  // Rule-level model of one clock edge.
  task automatic model_update(input bit cv, input int c, input bit cn, input bit ack, input bit rdy);
    int val;
    m_reject = (cv && (m_phase == P_VEND || m_phase == P_PAY || c == 3)) ? 1 : 0;
    case (m_phase)
      P_IDLE, P_COLLECT: begin
        val = cv ? coin_units(c) : 0;
        if (m_phase == P_COLLECT && cn) begin
          m_credit += val;
          m_phase  = P_PAY;
        end else if (val > 0) begin
          if (m_credit + val >= PRICE) begin
            m_credit = m_credit + val - PRICE;
            m_phase  = P_VEND;
          end else begin
            m_credit += val;
            m_phase  = P_COLLECT;
          end
        end
      end
      P_VEND: begin
        if (ack) m_phase = (m_credit != 0) ? P_PAY : P_IDLE;
      end
      default: begin
        if (rdy) begin
          m_credit -= largest_change(m_credit);
          if (m_credit == 0) m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  // One cycle: drive at the falling edge, clock, compare at the next falling edge.
  task automatic step(input bit cv, input int c, input bit cn, input bit ack, input bit rdy);
    coin_valid   = cv;
    coin         = 2'(c);
    cancel       = cn;
    vend_ack     = ack;
    change_ready = rdy;
    if (change_valid && rdy) paid_total += coin_units(int'(change_coin));
    model_update(cv, c, cn, ack, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_credit = 0;
    m_reject = 0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic hard_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_vend",         int'(vend),         0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change_coin",  int'(change_coin),  0);
    check("rst_coin_reject",  int'(coin_reject),  0);
    check("rst_credit",       int'(credit),       0);
    check("rst_busy",         int'(busy),         0);
    coin_valid   = 1'b0;
    coin         = 2'd0;
    cancel       = 1'b0;
    vend_ack     = 1'b0;
    change_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    clk          = 1'b0;
    reset_n      = 1'b0;
    coin_valid   = 1'b0;
    coin         = 2'd0;
    cancel       = 1'b0;
    vend_ack     = 1'b0;
    change_ready = 1'b0;
    n_tests      = 0;
    n_fail       = 0;
    paid_total   = 0;
    model_reset();

    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // 20 then 50: vend with 30 credit, change 20 then 10.
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    check("d1_vend", int'(vend), 1);
    check("d1_credit", int'(credit), 30);
    step(0, 0, 0, 1, 1);
    check("d1_first_change", int'(change_coin), 1);
    step(0, 0, 0, 0, 1);
    check("d1_second_change", int'(change_coin), 0);
    step(0, 0, 0, 0, 1);
    check("d1_idle", int'(busy), 0);

    // 10,10,20: exact price, no change.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("d2_vend", int'(vend), 1);
    check("d2_credit", int'(credit), 0);
    step(0, 0, 0, 1, 0);
    check("d2_no_change", int'(change_valid), 0);

    // 20, then cancel with a 50 in the same cycle: refund 70, no vend.
    step(1, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0);
    check("d3_credit", int'(credit), 70);
    check("d3_no_vend", int'(vend), 0);
    check("d3_coin50", int'(change_coin), 2);
    step(0, 0, 0, 0, 1);
    check("d3_coin20", int'(change_coin), 1);
    step(0, 0, 0, 0, 1);

    // Coin during VEND rejected; invalid code in IDLE rejected.
    step(1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("d4_reject_vend", int'(coin_reject), 1);
    check("d4_credit_kept", int'(credit), 10);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0);
    check("d4_reject_bad", int'(coin_reject), 1);
    check("d4_credit_zero", int'(credit), 0);

    // Payout with change_ready toggling.
    step(1, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0);
    paid_total = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, bit'(i % 2));
    check("d5_total_paid", paid_total, 70);
    check("d5_idle", int'(busy), 0);

    // Reset mid-payout, then a 50 behaves as a first coin.
    step(1, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    hard_reset();
    step(1, 2, 0, 0, 0);
    check("d6_vend", int'(vend), 1);
    check("d6_credit", int'(credit), 10);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        hard_reset();
      end else begin
        step(bit'($urandom_range(0, 99) < 40),
             int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 99) < 10),
             bit'($urandom_range(0, 99) < 30),
             bit'($urandom_range(0, 99) < 60));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
